xfifo_rd_stream: RTL
====================

XFIFO_RD_STREAM -- requirements
Module: xfifo_rd_stream

Interface
REQ-001 Parameter dta_width, default 9'd8: data width; SHALL equal the dta_width of the attached fifo.
REQ-002 Parameter skid_depth, fixed at 2: output buffer entries; not user-overridable.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 fifo_rd_en  output  1  read enable to the fifo read port.
REQ-006 fifo_dout  input  dta_width  fifo registered read data.
REQ-007 fifo_empty  input  1  fifo empty flag.
REQ-008 fifo_valid  input  1  fifo read acknowledge; fifo_dout is valid this cycle.
REQ-009 fifo_underflow  input  1  fifo read error.
REQ-010 out_data  output  dta_width  stream data; head of buffer.
REQ-011 out_valid  output  1  out_data holds a word.
REQ-012 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-013 err  output  1  sticky protocol error flag.
REQ-014 occ  output  2  buffered word count, 0..2.

Function
REQ-015 Block SHALL convert the fifo's one-cycle-latency read port into a first-word-fall-through valid/ready stream, preserving word order.
REQ-016 State: 2-entry buffer (head, tail), occ counter, 1-bit inflight = fifo_rd_en registered.
REQ-017 pop = out_valid && out_ready; fifo_rd_en SHALL be combinational: ~fifo_empty && (occ + inflight - pop) < 2.
REQ-018 fifo_rd_en SHALL never assert while fifo_empty is high.
REQ-019 On fifo_valid, fifo_dout SHALL be written to head if buffer empty after this cycle's pop, else to tail.
REQ-020 Simultaneous pop and fifo_valid with occ=1: fifo_dout SHALL load head directly, occ stays 1.
REQ-021 Pop with occ=2: tail SHALL move to head same edge, occ becomes 1.
REQ-022 out_valid SHALL equal (occ != 0); out_data SHALL be head register, no combinational path from fifo_dout.
REQ-023 Sustained throughput SHALL be one word per cycle when fifo non-empty and out_ready held high, after 2-cycle initial latency (fifo_rd_en at T, out_valid at T+2: T+1 fifo_valid, T+2 head loaded... head registered at T+1 edge, visible T+2 at latest).
REQ-024 Latency: word read at cycle T SHALL appear on out_data at cycle T+2.
REQ-025 out_data and out_valid SHALL stay stable while out_valid && ~out_ready.
REQ-026 err SHALL set and hold on: fifo_underflow high; fifo_valid high while inflight low; fifo_valid arriving with occ=2 and no pop (overrun). Data in the overrun case SHALL be dropped, buffer unchanged.
REQ-027 occ SHALL never exceed 2 nor wrap below 0.

Reset
REQ-028 rst low SHALL asynchronously clear occ, inflight, err, head, tail to 0; out_valid=0, fifo_rd_en=0 while rst low.
REQ-029 Reset mid-transfer SHALL discard buffered and inflight words; a fifo_valid in the first cycle after release SHALL set err.
REQ-030 fifo and this block SHALL share rst so that release is coincident.

Structure
REQ-031 No shared package; block-local constants only (skid_depth).
REQ-032 Single flat module; no sub-module.
REQ-033 Top-level instantiates xfifo_sc plus xfifo_rd_stream with matching dta_width.

Verification
REQ-034 Fifo holds 0x11,0x22,0x33, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first fifo_rd_en; err=0.
REQ-035 Fifo holds 4 words, out_ready=0 -> exactly 2 fifo_rd_en pulses, occ=2, out_data=first word stable; then out_ready=1 -> remaining words stream in order, no gap.
REQ-036 out_ready toggling 1,0,1,0 with fifo fed every cycle -> no loss, no duplicate, occ<=2, fifo never overflows nor underflows.
REQ-037 Fifo empty throughout -> fifo_rd_en never asserts, out_valid=0, err=0.
REQ-038 Inject fifo_valid with inflight=0 -> err=1 next cycle and held until rst low; rst low mid-stream with occ=2 -> occ=0, out_valid=0 immediately.

Source files
------------

// File: rtl/xfifo_rd_stream.sv
// rtl/xfifo_rd_stream.sv - two-entry skid buffer turning a registered fifo read port into a valid/ready stream
module xfifo_rd_stream #(
    parameter logic [8:0] dta_width = 9'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fifo_rd_en,
    input  logic [dta_width-1:0] fifo_dout,
    input  logic                 fifo_empty,
    input  logic                 fifo_valid,
    input  logic                 fifo_underflow,
    output logic [dta_width-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [1:0]           occ
);

    localparam int         skid_depth = 2;
    localparam logic [1:0] occ_full   = 2'(skid_depth);

    logic [dta_width-1:0] head;
    logic [dta_width-1:0] tail;
    logic [1:0]           occ_q;
    logic                 inflight;
    logic                 err_q;

    logic                 pop;
    logic [2:0]           level;
    logic                 overrun;
    logic                 accept;
    logic                 err_set;

    assign pop = (occ_q != 2'd0) && out_ready;

    // Words already owned (buffered or on their way) once this cycle's pop has left.
    assign level = {1'b0, occ_q} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = rst && ~fifo_empty && (level < 3'(skid_depth));

    assign overrun = fifo_valid && (occ_q == occ_full) && !pop;
    // A read acknowledge we never asked for is flagged and its data discarded.
    assign accept  = fifo_valid && inflight && !overrun;
    assign err_set = fifo_underflow || (fifo_valid && !inflight) || overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            occ_q    <= 2'd0;
            inflight <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (err_set) begin
                err_q <= 1'b1;
            end
            case (occ_q)
                2'd0: begin
                    if (accept) begin
                        head  <= fifo_dout;
                        occ_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && accept) begin
                        head <= fifo_dout;
                    end else if (pop) begin
                        occ_q <= 2'd0;
                    end else if (accept) begin
                        tail  <= fifo_dout;
                        occ_q <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (accept) begin
                            tail <= fifo_dout;
                        end else begin
                            occ_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign out_data  = head;
    assign out_valid = (occ_q != 2'd0);
    assign err       = err_q;
    assign occ       = occ_q;

endmodule
